alu_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one ALU instance between `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake. It drives the ALU input bus for exactly one cycle with `CE` high, waits the command-dependent ALU latency, and captures `RES` and the flags. It then returns them on a single tagged response channel. It sits between the stimulus/host agents and the ALU, and is the only block driving the ALU input pins.

---
 rtl/alu_arb_pkg.sv | 28 ++
 rtl/alu_req_arbiter_rr_grant.sv | 35 +++
 rtl/alu_req_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_req_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter: FSM states,
// ALU bus widths, multiply command codes and the latency lookup.
package alu_arb_pkg;

    localparam int WIDTH     = 8;
    localparam int CMD_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    localparam logic [CMD_WIDTH-1:0] CMD_MUL_INC = 4'd9;
    localparam logic [CMD_WIDTH-1:0] CMD_MUL_SHL = 4'd10;

    // Multiplies (arithmetic mode only) take the longer ALU path.
    function automatic int unsigned alu_latency(
        input logic                 mode,
        input logic [CMD_WIDTH-1:0] cmd,
        input int unsigned          base_lat = 1,
        input int unsigned          mul_lat  = 2
    );
        return (mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL)) ? mul_lat : base_lat;
    endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_grant.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward with wrap; one-hot grant plus its index.
module rr_grant #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gidx
);

    // Rotate so that bit 0 is the requester sitting at ptr.
    logic [N-1:0] rotated;
    assign rotated = N'({req, req} >> ptr);

    always_comb begin
        int pos;
        int idx;
        // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        grant = '0;
        gidx  = '0;
        pos   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) pos = i;
        end
        idx = int'(ptr) + pos;
        if (idx >= N) idx = idx - N;
        if (|req) begin
            grant[idx] = 1'b1;
            gidx       = IW'(idx);
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin accept, one-cycle
// issue with CE, latency wait, capture, tagged response with backpressure.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int          NUM_REQ  = 4,
    parameter  int unsigned BASE_LAT = 1,
    parameter  int unsigned MUL_LAT  = 2,
    localparam int          IDW      = $clog2(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_mode,
    input  logic [NUM_REQ-1:0]            req_cin,
    input  logic [2*NUM_REQ-1:0]          req_inp_valid,
    input  logic [CMD_WIDTH*NUM_REQ-1:0]  req_cmd,
    input  logic [WIDTH*NUM_REQ-1:0]      req_opa,
    input  logic [WIDTH*NUM_REQ-1:0]      req_opb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [IDW-1:0]                rsp_id,
    output logic [WIDTH:0]                rsp_res,
    output logic [6:0]                    rsp_flags,
    output logic                          CE,
    output logic                          MODE,
    output logic                          CIN,
    output logic [1:0]                    INP_VALID,
    output logic [CMD_WIDTH-1:0]          CMD,
    output logic [WIDTH-1:0]              OPA,
    output logic [WIDTH-1:0]              OPB,
    input  logic [WIDTH:0]                RES,
    input  logic                          ERR,
    input  logic                          OFLOW,
    input  logic                          COUT,
    input  logic                          G,
    input  logic                          L,
    input  logic                          E
);

    localparam int unsigned MAX_LAT = (MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT;
    localparam int          LAT_W   = $clog2(MAX_LAT + 1);

    arb_state_e           state;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       owner;
    logic [LAT_W-1:0]     lat_cnt;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       gidx;

    rr_grant #(.N(NUM_REQ)) u_grant (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .gidx  (gidx)
    );

    // Accept strobe is combinational and only meaningful while idle.
    assign req_ready = (state == ST_IDLE && !RST) ? grant : '0;

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep every read in this block at its pre-edge value.
        if (RST) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            lat_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_res   <= '0;
            rsp_flags <= '0;
            CE        <= 1'b0;
            MODE      <= 1'b0;
            CIN       <= 1'b0;
            INP_VALID <= '0;
            CMD       <= '0;
            OPA       <= '0;
            OPB       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        // The ALU pin registers double as the latched request.
                        CE        <= 1'b1;
                        MODE      <= req_mode[gidx];
                        CIN       <= req_cin[gidx];
                        INP_VALID <= req_inp_valid[2*int'(gidx) +: 2];
                        CMD       <= req_cmd[CMD_WIDTH*int'(gidx) +: CMD_WIDTH];
                        OPA       <= req_opa[WIDTH*int'(gidx) +: WIDTH];
                        OPB       <= req_opb[WIDTH*int'(gidx) +: WIDTH];
                        owner     <= gidx;
                        rr_ptr    <= (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    lat_cnt   <= LAT_W'(alu_latency(MODE, CMD, BASE_LAT, MUL_LAT));
                    CE        <= 1'b0;
                    MODE      <= 1'b0;
                    CIN       <= 1'b0;
                    INP_VALID <= '0;
                    CMD       <= '0;
                    OPA       <= '0;
                    OPB       <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt <= LAT_W'(1)) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= owner;
                        rsp_res   <= RES;
                        rsp_flags <= {ERR, OFLOW, COUT, G, L, E, 1'b0};
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench: stand-in ALU, transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_alu_req_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int CW = 4;
    localparam int BL = 1;
    localparam int ML = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NR-1:0]     req_valid, req_ready, req_mode, req_cin;
    logic [2*NR-1:0]   req_inp_valid;
    logic [CW*NR-1:0]  req_cmd;
    logic [W*NR-1:0]   req_opa, req_opb;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_id;
    logic [W:0]        rsp_res;
    logic [6:0]        rsp_flags;
    logic              CE, MODE, CIN;
    logic [1:0]        INP_VALID;
    logic [CW-1:0]     CMD;
    logic [W-1:0]      OPA, OPB;
    logic [W:0]        RES;
    logic              ERR, OFLOW, COUT, G, L, E;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    alu_req_arbiter #(.NUM_REQ(NR), .BASE_LAT(BL), .MUL_LAT(ML)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_cin(req_cin), .req_inp_valid(req_inp_valid),
        .req_cmd(req_cmd), .req_opa(req_opa), .req_opb(req_opb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags),
        .CE(CE), .MODE(MODE), .CIN(CIN), .INP_VALID(INP_VALID),
        .CMD(CMD), .OPA(OPA), .OPB(OPB),
        .RES(RES), .ERR(ERR), .OFLOW(OFLOW), .COUT(COUT), .G(G), .L(L), .E(E)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stand-in ALU function: returns {ERR,OFLOW,COUT,G,L,E,RES}.
    function automatic logic [14:0] alu_fn(input logic mode, input logic cin, input logic [1:0] iv,
                                           input logic [CW-1:0] cmd, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W:0] r, ea, eb;
        logic       err;
        ea  = {1'b0, a};
        eb  = {1'b0, b};
        err = (iv == 2'b00) || (cmd > 4'd13);
        if (mode) begin
            case (cmd)
                4'd0:    r = ea + eb;
                4'd1:    r = ea - eb;
                4'd9:    r = (ea + 9'd1) * (eb + 9'd1);
                4'd10:   r = (ea << 1) * eb;
                default: r = (ea ^ eb) + {8'd0, cin};
            endcase
        end else begin
            r = {cmd[0], a ^ ~b};
        end
        if (err) r = '0;
        return {err, r[7] ^ a[7], r[W], a > b, a < b, a == b, r};
    endfunction

    // Stand-in ALU: result valid only in the capture cycle, junk otherwise.
    logic [14:0] alu_out  = '0;
    logic [14:0] alu_junk = '0;
    logic [14:0] alu_bus;
    int          alu_cnt  = 0;

    always @(posedge CLK) begin
        alu_junk <= 15'($urandom);
        if (CE) begin
            alu_out <= alu_fn(MODE, CIN, INP_VALID, CMD, OPA, OPB);
            alu_cnt <= (MODE && (CMD == 4'd9 || CMD == 4'd10)) ? ML : BL;
        end else if (alu_cnt > 0) begin
            alu_cnt <= alu_cnt - 1;
        end
    end

    assign alu_bus = (alu_cnt == 1) ? alu_out : alu_junk;
    assign {ERR, OFLOW, COUT, G, L, E, RES} = alu_bus;

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int off = 0; off < NR; off++) begin
            if (v[(p + off) % NR]) return (p + off) % NR;
        end
        return -1;
    endfunction

    // Reference model: cycles since accept decide what every output must be.
    bit          m_busy = 1'b0;
    int          m_k    = 0;
    int          m_ptr  = 0;
    int          m_g    = 0;
    int          m_lat  = 0;
    logic [23:0] m_pins = '0;
    logic [14:0] m_exp  = '0;

    always @(negedge CLK) begin : model_cmp
        int          gg;
        logic [NR-1:0] e_ready;
        logic [23:0] e_pins;
        logic        e_ce, e_rv;
        if (chk_en) begin
            gg      = -1;
            e_ready = '0;
            e_pins  = '0;
            e_ce    = 1'b0;
            e_rv    = 1'b0;
            if (!m_busy) begin
                if (!RST) gg = pick(req_valid, m_ptr);
                if (gg >= 0) e_ready[gg] = 1'b1;
            end else if (m_k == 1) begin
                e_ce   = 1'b1;
                e_pins = m_pins;
            end else if (m_k >= 2 + m_lat) begin
                e_rv = 1'b1;
            end
            check("m_req_ready", 32'(req_ready), 32'(e_ready));
            check("m_ce", 32'(CE), 32'(e_ce));
            check("m_alu_pins", 32'({MODE, CIN, INP_VALID, CMD, OPA, OPB}), 32'(e_pins));
            check("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
            if (e_rv) begin
                check("m_rsp_id", 32'(rsp_id), 32'(m_g));
                check("m_rsp_res", 32'(rsp_res), 32'(m_exp[8:0]));
                check("m_rsp_flags", 32'(rsp_flags), 32'({m_exp[14:9], 1'b0}));
            end
            if (RST) begin
                m_busy = 1'b0;
                m_ptr  = 0;
            end else if (!m_busy) begin
                if (gg >= 0) begin
                    m_busy = 1'b1;
                    m_k    = 1;
                    m_g    = gg;
                    m_ptr  = (gg + 1) % NR;
                    m_pins = {req_mode[gg], req_cin[gg], req_inp_valid[gg*2 +: 2],
                              req_cmd[gg*CW +: CW], req_opa[gg*W +: W], req_opb[gg*W +: W]};
                    m_lat  = (req_mode[gg] && (req_cmd[gg*CW +: CW] == 4'd9 ||
                              req_cmd[gg*CW +: CW] == 4'd10)) ? ML : BL;
                    m_exp  = alu_fn(req_mode[gg], req_cin[gg], req_inp_valid[gg*2 +: 2],
                                    req_cmd[gg*CW +: CW], req_opa[gg*W +: W], req_opb[gg*W +: W]);
                end
            end else if (m_k >= 2 + m_lat) begin
                if (rsp_ready) m_busy = 1'b0;
            end else begin
                m_k++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic mode, input logic cin, input logic [1:0] iv,
                           input logic [CW-1:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        req_mode[i]              = mode;
        req_cin[i]               = cin;
        req_inp_valid[i*2 +: 2]  = iv;
        req_cmd[i*CW +: CW]      = cmd;
        req_opa[i*W +: W]        = a;
        req_opb[i*W +: W]        = b;
        req_valid[i]             = 1'b1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic accept_wait(input int i, input string name);
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge CLK);
            got = req_ready[i];
        end
        check({name, "_accepted"}, 32'(got), 32'd1);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic rsp_wait(input string name);
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge CLK);
            got = rsp_valid;
        end
        check({name, "_rsp_seen"}, 32'(got), 32'd1);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
        check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({pfx, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({pfx, "_rsp_res"}, 32'(rsp_res), 32'd0);
        check({pfx, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
        check({pfx, "_ce"}, 32'(CE), 32'd0);
        check({pfx, "_alu_pins"}, 32'({MODE, CIN, INP_VALID, CMD, OPA, OPB}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        logic [14:0]  exp;
        int           n;

        RST = 1'b1;
        req_valid = '0; req_mode = '0; req_cin = '0; req_inp_valid = '0;
        req_cmd = '0; req_opa = '0; req_opb = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        @(negedge CLK);
        check_zero("reset");
        chk_en = 1'b1;
        tick();
        RST = 1'b0;

        // Single ADD from requester 2.
        set_req(2, 1'b1, 1'b0, 2'b11, 4'd0, 8'h0F, 8'h01);
        @(negedge CLK);
        check("add_ready_T", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        @(negedge CLK);
        check("add_ce_T1", 32'(CE), 32'd1);
        check("add_opa_T1", 32'(OPA), 32'h0F);
        tick();
        @(negedge CLK);
        check("add_rv_T2", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge CLK);
        check("add_rv_T3", 32'(rsp_valid), 32'd1);
        check("add_id_T3", 32'(rsp_id), 32'd2);
        check("add_res_T3", 32'(rsp_res), 32'h010);
        tick();

        // Multiply latency from requester 0.
        set_req(0, 1'b1, 1'b0, 2'b11, 4'd9, 8'd3, 8'd4);
        @(negedge CLK);
        check("mul_ready_T", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        tick();
        @(negedge CLK);
        check("mul_rv_T3", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge CLK);
        check("mul_rv_T4", 32'(rsp_valid), 32'd1);
        check("mul_res_T4", 32'(rsp_res), 32'h014);
        tick();

        // Fairness with all requesters asserting.
        do_reset();
        for (int i = 0; i < NR; i++)
            set_req(i, 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom));
        n = 0;
        for (int c = 0; c < 200 && n < 8; c++) begin
            @(negedge CLK);
            if (rsp_valid && rsp_ready) begin
                check($sformatf("fair_id%0d", n), 32'(rsp_id), 32'(n % NR));
                n++;
            end
        end
        check("fair_count", 32'(n), 32'd8);
        tick();
        req_valid = '0;

        // Backpressure: response held for 10 cycles while requester 3 waits.
        tick();
        rsp_ready = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        exp = alu_fn(1'b1, 1'b0, 2'b11, 4'd2, a, b);
        set_req(1, 1'b1, 1'b0, 2'b11, 4'd2, a, b);
        accept_wait(1, "bp");
        set_req(3, 1'b1, 1'b1, 2'b11, 4'd0, 8'h11, 8'h22);
        rsp_wait("bp");
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge CLK);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_id", 32'(rsp_id), 32'd1);
            check("bp_res", 32'(rsp_res), 32'(exp[8:0]));
            check("bp_flags", 32'(rsp_flags), 32'({exp[14:9], 1'b0}));
            check("bp_no_accept", 32'(req_ready), 32'd0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge CLK);
        check("bp_release_valid", 32'(rsp_valid), 32'd1);
        tick();
        @(negedge CLK);
        check("bp_done", 32'(rsp_valid), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        rsp_wait("bp3");
        tick();

        // Error pass-through.
        set_req(2, 1'b0, 1'b0, 2'b00, 4'd14, 8'($urandom), 8'($urandom));
        accept_wait(2, "err");
        rsp_wait("err");
        check("err_flag", 32'(rsp_flags[6]), 32'd1);
        check("err_id", 32'(rsp_id), 32'd2);
        tick();

        // Reset asserted during the wait cycle.
        set_req(2, 1'b1, 1'b0, 2'b11, 4'd0, 8'h21, 8'h05);
        accept_wait(2, "mid");
        @(negedge CLK);
        check("mid_ce", 32'(CE), 32'd1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check_zero("midrst");
        for (int c = 0; c < 6; c++) begin
            tick();
            @(negedge CLK);
            check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        tick();
        for (int i = 0; i < NR; i++)
            set_req(i, 1'b1, 1'b0, 2'b11, 4'd0, 8'(i), 8'd1);
        @(negedge CLK);
        check("midrst_ptr0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        rsp_wait("midrst");
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            tick();
            RST           = ($urandom_range(0, 199) == 0);
            req_valid     = 4'($urandom) & 4'($urandom);
            req_mode      = 4'($urandom);
            req_cin       = 4'($urandom);
            req_inp_valid = 8'($urandom);
            req_cmd       = 16'($urandom);
            req_opa       = 32'($urandom);
            req_opb       = 32'($urandom);
            rsp_ready     = ($urandom_range(0, 3) != 0);
        end
        tick();
        RST       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
